sli_timing_gen: RTL

- Free-running raster timing and test-pixel generator for offline (no HDMI input) operation of the SLI projector path.
- Produces the RGB/blank/hsync/vsync bundle consumed directly by the pixel pipeline stage downstream.
- Default timing is CEA 1280x720p60, which matches the 720-row and 1280-column LUT geometry.
- Horizontal back porch of 220 clocks matches the downstream column-reset point.

---
 rtl/sli_timing_gen.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sli_timing_gen.sv
// Free-running raster timing and test-pixel generator for offline operation of
// the SLI projector path; drives the RGB/blank/sync bundle for the pixel pipeline.
module sli_timing_gen #(
    parameter int unsigned H_ACT  = 1280,
    parameter int unsigned H_FP   = 110,
    parameter int unsigned H_SYNC = 40,
    parameter int unsigned H_BP   = 220,
    parameter int unsigned V_ACT  = 720,
    parameter int unsigned V_FP   = 5,
    parameter int unsigned V_SYNC = 5,
    parameter int unsigned V_BP   = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [1:0]  pat,
    input  logic [7:0]  level,
    output logic [7:0]  out_red,
    output logic [7:0]  out_green,
    output logic [7:0]  out_blue,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_blank,
    output logic [10:0] col,
    output logic [9:0]  row,
    output logic        sof,
    output logic [15:0] frame_cnt
);
    localparam int unsigned HW    = 11;
    localparam int unsigned VW    = 10;
    localparam int unsigned PW    = 8;
    localparam int unsigned FW    = 16;
    localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACT + V_FP + V_SYNC);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]    pat_q, pat_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [HW-1:0] col_q, col_d;
    logic [VW-1:0] row_q, row_d;
    logic          blank_q, blank_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          sof_q, sof_d;

    logic          running, line_end, frame_end, origin, active;
    logic [1:0]    pat_cur;
    logic [PW-1:0] level_cur;

    always_comb begin
        running   = (state_q == S_RUN);
        line_end  = (hcnt_q == H_LAST);
        frame_end = running && line_end && (vcnt_q == V_LAST);
        origin    = running && (hcnt_q == '0) && (vcnt_q == '0);
        active    = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Stopping is only honoured at the last counter cycle, so frames are never cut short
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (frame_end && !en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Raster counters, frame counter and once-per-frame pattern capture
    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        level_d     = level_q;
        if (running) begin
            if (line_end) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
            if (frame_end) frame_cnt_d = frame_cnt_q + FW'(1);
            if (origin) begin
                pat_d   = pat;
                level_d = level;
            end
        end
    end

    // Output decode; pixel (0,0) uses the freshly sampled pattern, not last frame's
    always_comb begin
        blank_d   = 1'b1;
        hsync_d   = 1'b0;
        vsync_d   = 1'b0;
        sof_d     = 1'b0;
        col_d     = '0;
        row_d     = '0;
        pix_d     = '0;
        pat_cur   = origin ? pat : pat_q;
        level_cur = origin ? level : level_q;
        if (running) begin
            hsync_d = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
            vsync_d = ((vcnt_q == VS_BEG) && (hcnt_q >= HS_BEG)) ||
                      ((vcnt_q > VS_BEG) && (vcnt_q < VS_END)) ||
                      ((vcnt_q == VS_END) && (hcnt_q < HS_BEG));
            sof_d   = origin;
            if (active) begin
                blank_d = 1'b0;
                col_d   = hcnt_q;
                row_d   = vcnt_q;
                case (pat_cur)
                    2'd0:    pix_d = level_cur;
                    2'd1:    pix_d = hcnt_q[PW-1:0];
                    2'd2:    pix_d = vcnt_q[PW-1:0];
                    default: pix_d = {PW{hcnt_q[6] ^ vcnt_q[6]}};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
            pat_q       <= '0;
            level_q     <= '0;
            pix_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            blank_q     <= 1'b1;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            sof_q       <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            level_q     <= level_d;
            pix_q       <= pix_d;
            col_q       <= col_d;
            row_q       <= row_d;
            blank_q     <= blank_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            sof_q       <= sof_d;
        end
    end

    assign out_red   = pix_q;
    assign out_green = pix_q;
    assign out_blue  = pix_q;
    assign out_hsync = hsync_q;
    assign out_vsync = vsync_q;
    assign out_blank = blank_q;
    assign col       = col_q;
    assign row       = row_q;
    assign sof       = sof_q;
    assign frame_cnt = frame_cnt_q;

endmodule
